uart_frame_sched: RTL and testbench

Frame sequencer that drives the existing byte-level UART transmitter (16 clocks/bit, rising-edge update, busy flag).
- Host loads up to MAX_LEN payload bytes into an internal buffer, then pulses start.
- Block emits HEADER, length byte, payload bytes, then CRC-8 over length+payload, one byte per UART frame.
- Owns the transmitter's datain/update handshake, including its 2-cycle edge-detect latency and its requirement that datain stays stable for the whole frame.

---
 rtl/uart_frame_sched_pkg.sv | 22 ++
 rtl/uart_frame_sched_crc8_unit.sv | 46 ++++
 rtl/uart_frame_sched.sv | 197 +++++++++++++++++++
 tb/tb_uart_frame_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_sched_pkg.sv
// Shared encodings for the UART frame sequencer: controller states and
// the frame phase that selects which byte goes out next.
package uart_frame_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_ARM,
        ST_DRAIN,
        ST_GAP,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_HDR,
        PH_LEN,
        PH_PAY,
        PH_CRC
    } phase_e;

endpackage

// File: rtl/uart_frame_sched_crc8_unit.sv
// Bytewise CRC-8 (MSB-first, no reflection). One byte is folded in per
// enabled cycle; init reseeds the register and takes priority over en.
module crc8_unit #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = INIT;
        end else if (en) begin
            crc_d = crc8_step(crc_q, din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/uart_frame_sched.sv
// Frame sequencer in front of a byte UART: sends HEADER, length, buffered
// payload and a CRC-8, driving the transmitter's datain/update handshake.
module uart_frame_sched
    import uart_frame_sched_pkg::*;
#(
    parameter int         MAX_LEN  = 16,
    parameter logic [7:0] HEADER   = 8'hAA,
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00,
    parameter int         BUSY_TO  = 8,
    localparam int        LW       = $clog2(MAX_LEN + 1),
    localparam int        AW       = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          frame_busy,
    output logic          done,
    output logic          err,
    output logic          wr_full,
    output logic [7:0]    tx_data,
    output logic          tx_update,
    input  logic          tx_busy
);

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] wptr_q, wptr_d;
    logic [7:0]    to_cnt_q, to_cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_update_q, tx_update_d;
    logic          frame_busy_q, frame_busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          buf_we;
    logic          crc_init;
    logic          crc_en;
    logic [7:0]    byte_sel;
    logic [7:0]    crc_val;
    logic [7:0]    buf_mem [MAX_LEN];

    crc8_unit #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init),
        .en    (crc_en),
        .din   (byte_sel),
        .crc   (crc_val)
    );

    assign wr_full = (wptr_q == LW'(MAX_LEN));

    always_comb begin
        byte_sel = HEADER;
        case (phase_q)
            PH_HDR:  byte_sel = HEADER;
            PH_LEN:  byte_sel = 8'(len_q);
            PH_PAY:  byte_sel = buf_mem[idx_q[AW-1:0]];
            PH_CRC:  byte_sel = crc_val;
            default: byte_sel = HEADER;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        idx_d        = idx_q;
        len_d        = len_q;
        wptr_d       = wptr_q;
        to_cnt_d     = to_cnt_q;
        tx_data_d    = tx_data_q;
        tx_update_d  = 1'b0;
        frame_busy_d = frame_busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        buf_we       = 1'b0;
        crc_init     = 1'b0;
        crc_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    wptr_d = '0;
                end else if (wr_en && !wr_full) begin
                    buf_we = 1'b1;
                    wptr_d = wptr_q + LW'(1);
                end
                if (start) begin
                    if ((len > wptr_q) || (len > LW'(MAX_LEN))) begin
                        err_d = 1'b1;
                    end else begin
                        len_d        = len;
                        crc_init     = 1'b1;
                        frame_busy_d = 1'b1;
                        phase_d      = PH_HDR;
                        idx_d        = '0;
                        state_d      = ST_SYNC;
                    end
                end
            end
            // The transmitter may still be finishing a byte started before our reset.
            ST_SYNC: begin
                if (!tx_busy) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_data_d   = byte_sel;
                crc_en      = (phase_q == PH_LEN) || (phase_q == PH_PAY);
                to_cnt_d    = '0;
                tx_update_d = 1'b1;
                state_d     = ST_ARM;
            end
            ST_ARM: begin
                if (tx_busy) begin
                    state_d = ST_DRAIN;
                end else if (to_cnt_q == 8'(BUSY_TO - 1)) begin
                    err_d        = 1'b1;
                    frame_busy_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    to_cnt_d    = to_cnt_q + 8'd1;
                    tx_update_d = 1'b1;
                end
            end
            // tx_data must stay put: the transmitter samples it for the whole byte.
            ST_DRAIN: begin
                if (!tx_busy) state_d = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_LOAD;
                case (phase_q)
                    PH_HDR: phase_d = PH_LEN;
                    PH_LEN: phase_d = (len_q != '0) ? PH_PAY : PH_CRC;
                    PH_PAY: begin
                        if (idx_q + LW'(1) == len_q) phase_d = PH_CRC;
                        else                         idx_d   = idx_q + LW'(1);
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_DONE: begin
                done_d       = 1'b1;
                frame_busy_d = 1'b0;
                wptr_d       = '0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_HDR;
            idx_q        <= '0;
            len_q        <= '0;
            wptr_q       <= '0;
            to_cnt_q     <= '0;
            tx_data_q    <= 8'h00;
            tx_update_q  <= 1'b0;
            frame_busy_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            wptr_q       <= wptr_d;
            to_cnt_q     <= to_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_update_q  <= tx_update_d;
            frame_busy_q <= frame_busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[wptr_q[AW-1:0]] <= wr_data;
    end

    assign tx_data    = tx_data_q;
    assign tx_update  = tx_update_q;
    assign frame_busy = frame_busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench for uart_frame_sched with a behavioural byte-UART model
// (2-cycle update edge detect, 160-cycle busy window) capturing sent bytes.
module tb_uart_frame_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic [4:0] len = 5'd0;
    logic       frame_busy, done, err, wr_full, tx_update, tx_busy;
    logic [7:0] tx_data;

    logic       busy_m = 1'b0;
    logic       upd_d1 = 1'b0;
    logic       upd_d2 = 1'b0;
    logic [7:0] cap = 8'h00;
    int         mcnt = 0;
    int         stab_err = 0;
    logic       ovr_en = 1'b0;
    logic       ovr_val = 1'b0;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    int errors = 0;
    int checks = 0;

    uart_frame_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr        (clr),
        .start      (start),
        .len        (len),
        .frame_busy (frame_busy),
        .done       (done),
        .err        (err),
        .wr_full    (wr_full),
        .tx_data    (tx_data),
        .tx_update  (tx_update),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = ovr_en ? ovr_val : busy_m;

    // Transmitter model: detects update rising edge one cycle late, then busy 160 cycles.
    always @(posedge clk) begin
        upd_d1 <= tx_update;
        upd_d2 <= upd_d1;
        if (busy_m) begin
            if (tx_data !== cap) stab_err++;
            if (mcnt == 159) begin
                busy_m <= 1'b0;
                rx_q.push_back(cap);
            end
            mcnt <= mcnt + 1;
        end else if (!ovr_en && upd_d1 && !upd_d2) begin
            busy_m <= 1'b1;
            mcnt   <= 0;
            cap    <= tx_data;
        end
    end

    function automatic logic [7:0] crc_ref(input logic [7:0] c_in, input logic [7:0] b);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] l);
        @(negedge clk);
        start = 1'b1;
        len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_low"}, frame_busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
        check({tag, "_stable"}, stab_err, 0);
        rx_q.delete();
        stab_err = 0;
    endtask

    initial begin
        logic [7:0] crc;
        logic [7:0] pay [16];
        int n;
        int hi;

        repeat (3) @(negedge clk);
        check("rst_busy", frame_busy, 0);
        check("rst_update", tx_update, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_done_err", {done, err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_full", wr_full, 0);

        // Single zero payload byte.
        wr_byte(8'h00);
        do_start(5'd1);
        check("t1_accept", {frame_busy, err}, 2'b10);
        wait_done("t1", 2000);
        exp_q = {8'hAA, 8'h01, 8'h00, 8'h15};
        check_frame("t1");
        check("t1_full", wr_full, 0);

        // Empty payload.
        do_start(5'd0);
        check("t2_accept", {frame_busy, err}, 2'b10);
        wait_done("t2", 2000);
        exp_q = {8'hAA, 8'h00, 8'h00};
        check_frame("t2");

        // len larger than buffered bytes.
        wr_byte(8'h31);
        wr_byte(8'h32);
        wr_byte(8'h33);
        do_start(5'd4);
        check("t3_err", err, 1);
        check("t3_busy", frame_busy, 0);
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            hi += int'(tx_update);
        end
        check("t3_no_update", hi, 0);
        check("t3_err_pulse", err, 0);
        @(negedge clk);
        clr = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h77;
        @(negedge clk);
        clr = 1'b0;
        wr_en = 1'b0;
        do_start(5'd1);
        check("t3_clr_prio", err, 1);

        // Full buffer.
        for (int i = 0; i < 16; i++) begin
            pay[i] = 8'(i * 29 + 7);
            wr_byte(pay[i]);
        end
        check("t4_full", wr_full, 1);
        wr_byte(8'hEE);
        check("t4_full_hold", wr_full, 1);
        do_start(5'd16);
        check("t4_accept", {frame_busy, err}, 2'b10);
        wait_done("t4", 5000);
        crc = crc_ref(8'h00, 8'h10);
        exp_q = {8'hAA, 8'h10};
        for (int i = 0; i < 16; i++) begin
            crc = crc_ref(crc, pay[i]);
            exp_q.push_back(pay[i]);
        end
        exp_q.push_back(crc);
        check_frame("t4");
        check("t4_full_clr", wr_full, 0);

        // Transmitter never raises busy.
        ovr_en = 1'b1;
        ovr_val = 1'b0;
        wr_byte(8'h5A);
        do_start(5'd1);
        check("t5_accept", frame_busy, 1);
        n = 0;
        hi = 0;
        while (err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            hi += int'(tx_update);
        end
        check("t5_err_cycle", n, 10);
        check("t5_arm_cycles", hi, 8);
        check("t5_update_low", tx_update, 0);
        check("t5_busy_low", frame_busy, 0);
        @(negedge clk);
        check("t5_err_pulse", err, 0);
        do_start(5'd2);
        check("t5_ptr_not2", err, 1);
        ovr_en = 1'b0;
        do_start(5'd1);
        check("t5_retry", {frame_busy, err}, 2'b10);
        wait_done("t5", 2000);
        exp_q = {8'hAA, 8'h01, 8'h5A, crc_ref(crc_ref(8'h00, 8'h01), 8'h5A)};
        check_frame("t5");

        // Reset mid-payload while the transmitter is busy.
        wr_byte(8'h01);
        wr_byte(8'h02);
        wr_byte(8'h03);
        wr_byte(8'h04);
        do_start(5'd4);
        n = 0;
        while (!(rx_q.size() == 2 && busy_m) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_pay", int'(rx_q.size() == 2 && busy_m), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", frame_busy, 0);
        check("t6_rst_update", tx_update, 0);
        check("t6_rst_data", tx_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_byte(8'h11);
        wr_byte(8'h22);
        do_start(5'd2);
        check("t6_accept", {frame_busy, err}, 2'b10);
        check("t6_tx_still_busy", busy_m, 1);
        n = 0;
        hi = 0;
        while (busy_m && n < 300) begin
            @(negedge clk);
            n++;
            hi += int'(tx_update);
        end
        check("t6_sync_no_update", hi, 0);
        check("t6_sync_busy", frame_busy, 1);
        rx_q.delete();
        stab_err = 0;
        wait_done("t6", 2000);
        exp_q = {8'hAA, 8'h02, 8'h11, 8'h22,
                 crc_ref(crc_ref(crc_ref(8'h00, 8'h02), 8'h11), 8'h22)};
        check_frame("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
